// File: rtl/fir_tdm_mac_pkg.sv
// Shared fixed-point formats, FSM state encoding and a ceiling-log2 helper
// for the time-multiplexed FIR filter.
package fir_tdm_mac_pkg;

    // Narrow format (9,7): samples and coefficients
    localparam int FX_NARROW_NB  = 9;
    localparam int FX_NARROW_NBF = 7;

    // Wide format (17,10): filter output
    localparam int FX_WIDE_NB    = 17;
    localparam int FX_WIDE_NBF   = 10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MAC  = 2'd1,
        ST_OUT  = 2'd2
    } state_e;

    // Number of bits needed to index 'value' entries (minimum 0)
    function automatic int clog2(input int value);
        int res;
        int rem;
        res = 0;
        rem = value - 1;
        while (rem > 0) begin
            res = res + 1;
            rem = rem >> 1;
        end
        return res;
    endfunction

endpackage

// File: rtl/fir_tdm_mac_sat_trunc.sv
// Requantiser: drops fraction bits (floor, or round-half-up when ROUND=1)
// and saturates the result into a narrower signed word.
module fir_tdm_mac_sat_trunc #(
    parameter int NB_I  = 21,
    parameter int NBF_I = 14,
    parameter int NB_O  = 17,
    parameter int NBF_O = 10,
    parameter int ROUND = 0
) (
    input  logic signed [NB_I-1:0] i_data,
    output logic signed [NB_O-1:0] o_data
);

    localparam int SH  = NBF_I - NBF_O;
    localparam int HSH = (SH > 0) ? (SH - 1) : 0;
    // One guard bit above the input so the rounding add cannot wrap
    localparam int W   = ((NB_I + 1) > NB_O) ? (NB_I + 1) : NB_O;

    localparam logic signed [W-1:0] HALF   = ((ROUND != 0) && (SH > 0)) ? (W'(1) <<< HSH) : W'(0);
    localparam logic signed [W-1:0] HI_LIM = (W'(1) <<< (NB_O - 1)) - W'(1);
    localparam logic signed [W-1:0] LO_LIM = -(W'(1) <<< (NB_O - 1));

    logic signed [W-1:0] ext_s;
    logic signed [W-1:0] shifted_s;

    // Align the binary point, then clamp to the output range
    always_comb begin
        ext_s     = W'(i_data);
        shifted_s = (ext_s + HALF) >>> SH;
        if (shifted_s > HI_LIM) begin
            o_data = HI_LIM[NB_O-1:0];
        end else if (shifted_s < LO_LIM) begin
            o_data = LO_LIM[NB_O-1:0];
        end else begin
            o_data = shifted_s[NB_O-1:0];
        end
    end

endmodule

// File: rtl/fir_tdm_mac.sv
// Time-multiplexed FIR filter: a single multiply-accumulate unit walks all
// N_TAPS taps for each accepted sample, then presents one requantised output.
module fir_tdm_mac
    import fir_tdm_mac_pkg::*;
#(
    parameter int N_TAPS = 8,
    parameter int NB_X   = FX_NARROW_NB,
    parameter int NBF_X  = FX_NARROW_NBF,
    parameter int NB_C   = FX_NARROW_NB,
    parameter int NBF_C  = FX_NARROW_NBF,
    parameter int NB_O   = FX_WIDE_NB,
    parameter int NBF_O  = FX_WIDE_NBF
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_valid,
    output logic                      o_ready,
    input  logic signed [NB_X-1:0]    i_data,
    input  logic                      i_coef_we,
    input  logic [clog2(N_TAPS)-1:0]  i_coef_addr,
    input  logic signed [NB_C-1:0]    i_coef_data,
    output logic                      o_valid,
    output logic signed [NB_O-1:0]    o_data
);

    localparam int AW     = clog2(N_TAPS);
    localparam int NB_P   = NB_X + NB_C;
    localparam int NB_ACC = NB_P + AW;
    localparam int FRAC_P = NBF_X + NBF_C;

    state_e                   state_q;
    logic                     o_ready_q;
    logic                     o_valid_q;
    logic signed [NB_O-1:0]   o_data_q;
    logic signed [NB_ACC-1:0] acc_q;
    logic signed [NB_ACC-1:0] acc_d;
    logic [AW-1:0]            k_q;
    logic [AW-1:0]            wr_ptr_q;
    logic signed [NB_X-1:0]   delay_q [N_TAPS];
    logic signed [NB_C-1:0]   coef_q  [N_TAPS];

    logic                     accept_s;
    logic                     coef_wr_s;
    logic [AW-1:0]            idx_s;
    logic signed [NB_P-1:0]   c_ext_s;
    logic signed [NB_P-1:0]   d_ext_s;
    logic signed [NB_P-1:0]   prod_s;
    logic signed [NB_O-1:0]   sat_out_s;

    assign accept_s  = (state_q == ST_IDLE) && o_ready_q && i_valid;
    assign coef_wr_s = (state_q == ST_IDLE) && i_coef_we;

    // Tap product for the current k; the delay index wraps naturally because N_TAPS is a power of two
    always_comb begin
        idx_s   = wr_ptr_q - k_q;
        c_ext_s = NB_P'(coef_q[k_q]);
        d_ext_s = NB_P'(delay_q[idx_s]);
        prod_s  = c_ext_s * d_ext_s;
        acc_d   = acc_q + NB_ACC'(prod_s);
    end

    // Coefficient bank: writable only while idle so an in-flight sample sees a stable set
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < N_TAPS; i++) begin
                coef_q[i] <= '0;
            end
        end else if (coef_wr_s) begin
            coef_q[i_coef_addr] <= i_coef_data;
        end
    end

    // Delay line: the accepted sample lands at the write pointer
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < N_TAPS; i++) begin
                delay_q[i] <= '0;
            end
        end else if (accept_s) begin
            delay_q[wr_ptr_q] <= i_data;
        end
    end

    // Control FSM and MAC datapath: IDLE accepts, MAC runs N_TAPS taps, OUT publishes the result
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= ST_IDLE;
            o_ready_q <= 1'b0;
            o_valid_q <= 1'b0;
            o_data_q  <= '0;
            acc_q     <= '0;
            k_q       <= '0;
            wr_ptr_q  <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    o_valid_q <= 1'b0;
                    if (accept_s) begin
                        acc_q     <= '0;
                        k_q       <= '0;
                        o_ready_q <= 1'b0;
                        state_q   <= ST_MAC;
                    end else begin
                        o_ready_q <= 1'b1;
                    end
                end
                ST_MAC: begin
                    o_valid_q <= 1'b0;
                    acc_q     <= acc_d;
                    k_q       <= k_q + AW'(1);
                    if (k_q == AW'(N_TAPS - 1)) begin
                        wr_ptr_q <= wr_ptr_q + AW'(1);
                        state_q  <= ST_OUT;
                    end
                end
                ST_OUT: begin
                    o_data_q  <= sat_out_s;
                    o_valid_q <= 1'b1;
                    o_ready_q <= 1'b1;
                    state_q   <= ST_IDLE;
                end
                default: begin
                    o_valid_q <= 1'b0;
                    o_ready_q <= 1'b0;
                    state_q   <= ST_IDLE;
                end
            endcase
        end
    end

    fir_tdm_mac_sat_trunc #(
        .NB_I  (NB_ACC),
        .NBF_I (FRAC_P),
        .NB_O  (NB_O),
        .NBF_O (NBF_O),
        .ROUND (0)
    ) u_sat_trunc (
        .i_data (acc_q),
        .o_data (sat_out_s)
    );

    assign o_ready = o_ready_q;
    assign o_valid = o_valid_q;
    assign o_data  = o_data_q;

endmodule

// File: tb/tb_fir_tdm_mac.sv
// Scoreboard bench for fir_tdm_mac: stimulus pushes golden results, a monitor pops on o_valid.
module tb_fir_tdm_mac;

    localparam int N      = 8;
    localparam int SH     = 7 + 7 - 10;
    localparam int Y_MAX  = 65535;
    localparam int Y_MIN  = -65536;
    localparam int LAT    = N + 1;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               valid = 1'b0;
    logic               ready;
    logic signed [8:0]  data = 9'sd0;
    logic               coef_we = 1'b0;
    logic [2:0]         coef_addr = 3'd0;
    logic signed [8:0]  coef_data = 9'sd0;
    logic               o_valid;
    logic signed [16:0] o_data;

    fir_tdm_mac dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_valid     (valid),
        .o_ready     (ready),
        .i_data      (data),
        .i_coef_we   (coef_we),
        .i_coef_addr (coef_addr),
        .i_coef_data (coef_data),
        .o_valid     (o_valid),
        .o_data      (o_data)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_err = 0;
    int h_m [N];
    int x_m [N];
    int exp_q [$];
    int acc_cyc_q [$];
    int last_exp = 0;

    task automatic check(input string name, input int act, input int exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp_v, cyc);
        end
    endtask

    // Golden: direct convolution over the last N samples, floor shift, saturate
    function automatic int golden();
        int s;
        s = 0;
        for (int k = 0; k < N; k++) s += h_m[k] * x_m[k];
        s = s >>> SH;
        if (s > Y_MAX) s = Y_MAX;
        if (s < Y_MIN) s = Y_MIN;
        return s;
    endfunction

    function automatic int model_accept(input int x);
        for (int k = N - 1; k > 0; k--) x_m[k] = x_m[k-1];
        x_m[0] = x;
        return golden();
    endfunction

    // Monitor: every output pulse must match the oldest expectation and its latency
    always @(negedge clk) begin
        if (o_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_valid", 1, 0);
            end else begin
                int e;
                int a;
                e = exp_q.pop_front();
                a = acc_cyc_q.pop_front();
                check("o_data", int'(o_data), e);
                check("latency", cyc - a, LAT);
                last_exp = e;
            end
        end
    end

    task automatic send(input int x, input bit has_exp, input int exp_v,
                        input bit wr, input int waddr, input int wdata);
        int  waited;
        bit  ok;
        int  e;
        waited = 0;
        ok = 1'b0;
        while (!ok && waited < 100) begin
            @(negedge clk);
            valid = 1'b1;
            data  = 9'(x);
            if (ready === 1'b1) begin
                if (wr) begin
                    coef_we   = 1'b1;
                    coef_addr = 3'(waddr);
                    coef_data = 9'(wdata);
                    h_m[waddr] = wdata;
                end
                e = model_accept(x);
                exp_q.push_back(has_exp ? exp_v : e);
                acc_cyc_q.push_back(cyc + 1);
                ok = 1'b1;
            end else begin
                waited++;
            end
        end
        if (!ok) check("send_timeout", 0, 1);
        @(negedge clk);
        valid   = 1'b0;
        coef_we = 1'b0;
    endtask

    task automatic wcoef(input int addr, input int val);
        @(negedge clk);
        coef_we   = 1'b1;
        coef_addr = 3'(addr);
        coef_data = 9'(val);
        h_m[addr] = val;
        @(negedge clk);
        coef_we = 1'b0;
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (exp_q.size() != 0) begin
            check("output_timeout", exp_q.size(), 0);
            exp_q.delete();
            acc_cyc_q.delete();
        end
        @(negedge clk);
        @(negedge clk);
        check("ready_when_idle", int'(ready), 1);
        check("o_data_hold", int'(o_data), last_exp);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        exp_q.delete();
        acc_cyc_q.delete();
        for (int k = 0; k < N; k++) begin
            h_m[k] = 0;
            x_m[k] = 0;
        end
        last_exp = 0;
        @(negedge clk);
        @(negedge clk);
        check("rst_ready", int'(ready), 0);
        check("rst_valid", int'(o_valid), 0);
        check("rst_data", int'(o_data), 0);
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_rst", int'(ready), 1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int ready_cnt;
        int prev;
        int x;

        // 1: unit tap
        do_reset();
        wcoef(0, 128);
        send(64, 1'b1, 512, 1'b0, 0, 0);
        wait_idle();

        // 2: impulse through ramp coefficients
        do_reset();
        for (int k = 0; k < N; k++) wcoef(k, k + 1);
        for (int i = 0; i < N; i++) send((i == 0) ? 128 : 0, 1'b1, 8 * (i + 1), 1'b0, 0, 0);
        send(0, 1'b1, 0, 1'b0, 0, 0);
        wait_idle();

        // 3: floor on negative values; coefficient written in the accepting cycle
        do_reset();
        send(-1, 1'b1, -1, 1'b1, 0, 1);
        send(1, 1'b1, 0, 1'b0, 0, 0);
        wait_idle();

        // 4: extreme magnitudes
        do_reset();
        for (int k = 0; k < N; k++) wcoef(k, -256);
        for (int i = 0; i < N; i++) send(-256, (i == N - 1), 32768, 1'b0, 0, 0);
        wait_idle();

        // 5: continuous valid, write attempted during MAC is dropped
        do_reset();
        for (int k = 0; k < N; k++) wcoef(k, int'($urandom_range(0, 511)) - 256);
        ready_cnt = 0;
        prev = -1;
        for (int c = 0; c < 45; c++) begin
            @(negedge clk);
            x = int'($urandom_range(0, 511)) - 256;
            valid     = 1'b1;
            data      = 9'(x);
            coef_we   = (c == 4);
            coef_addr = 3'd0;
            coef_data = ~9'(h_m[0]);
            if (ready === 1'b1) begin
                ready_cnt++;
                exp_q.push_back(model_accept(x));
                acc_cyc_q.push_back(cyc + 1);
                if (prev >= 0) check("accept_interval", cyc + 1 - prev, N + 2);
                prev = cyc + 1;
            end
        end
        @(negedge clk);
        valid   = 1'b0;
        coef_we = 1'b0;
        check("ready_cycles", ready_cnt, 5);
        wait_idle();

        // 6: reset in the third MAC cycle aborts the sample and clears state
        do_reset();
        for (int k = 0; k < N; k++) wcoef(k, 100);
        send(77, 1'b0, 0, 1'b0, 0, 0);
        @(negedge clk);
        do_reset();
        repeat (15) @(negedge clk);
        send(20, 1'b1, 0, 1'b0, 0, 0);
        wait_idle();
        for (int k = 0; k < N; k++) wcoef(k, 128);
        send(10, 1'b1, 240, 1'b0, 0, 0);
        wait_idle();

        // Randomised traffic
        do_reset();
        for (int r = 0; r < 4; r++) begin
            for (int k = 0; k < N; k++) wcoef(k, int'($urandom_range(0, 511)) - 256);
            for (int i = 0; i < 12; i++) begin
                repeat ($urandom_range(0, 3)) @(negedge clk);
                send(int'($urandom_range(0, 511)) - 256, 1'b0, 0,
                     ($urandom_range(0, 3) == 0), int'($urandom_range(0, N - 1)),
                     int'($urandom_range(0, 511)) - 256);
            end
            wait_idle();
        end

        check("scoreboard_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
